multicycle_controller: RTL and testbench

//  FSM control unit that sequences the shared ARM datapath (regfile, extend, ALU, muxes) one instruction

---
 rtl/ctrl_pkg.sv | 77 +++++++
 rtl/cond_unit.sv | 36 +++
 rtl/multicycle_controller.sv | 143 ++++++++++++++
 tb/tb_multicycle_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU ops,
// condition codes, mux selects and the ALU/condition decode helpers.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // flagw[1] enables the N/Z pair, flagw[0] the C/V pair
  typedef struct packed {
    alu_op_t    op;
    logic [1:0] flagw;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    case (cmd)
      4'b0100: d = '{op: ALU_ADD, flagw: 2'b11};
      4'b0010: d = '{op: ALU_SUB, flagw: 2'b11};
      4'b0000: d = '{op: ALU_AND, flagw: 2'b10};
      4'b1100: d = '{op: ALU_ORR, flagw: 2'b10};
      default: d = '{op: ALU_ADD, flagw: 2'b00};
    endcase
    return d;
  endfunction

  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond_t'(cond))
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and condition evaluation for the multicycle controller.
module cond_unit
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       capture,
  input  logic [1:0] flagw_req,
  output logic       condex
);

  logic [3:0] flags;
  logic       cond_q;
  logic [1:0] flagw;

  // Condition is frozen in DECODE so a flag update in EXEC cannot change
  // whether the same instruction's writeback commits.
  assign condex = cond_q;
  assign flagw  = flagw_req & {2{cond_q}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags  <= FLAG_RST;
      cond_q <= 1'b0;
    end else begin
      if (capture)  cond_q      <= cond_check(cond, flags);
      if (flagw[1]) flags[3:2]  <= alu_flags[3:2];
      if (flagw[0]) flags[1:0]  <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute over a shared
// memory port and gates every architectural write with the condition result.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter logic [3:0] PC_REG   = 4'hF,
  parameter logic [3:0] FLAG_RST = 4'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         mem_ready,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ALUControl,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic         RegWrite
);

  state_t     state, state_next;
  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  alu_dec_t   dec;
  logic       next_pc, regw, memw, branch, irw, capture, condex, pcs, pc_dest;
  logic [1:0] flagw_req;
  logic       unused_rn;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];
  assign dec       = alu_decode(funct[4:1]);

  cond_unit #(.FLAG_RST(FLAG_RST)) u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .capture   (capture),
    .flagw_req (flagw_req),
    .condex    (condex)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    next_pc    = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    irw        = 1'b0;
    capture    = 1'b0;
    flagw_req  = '0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WD;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        irw       = mem_ready;
        next_pc   = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        capture   = 1'b1;
        case (op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = funct[5] ? EXECI : EXECR;
          OP_BR:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        state_next = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        regw       = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? SRCB_IMM : SRCB_WD;
        ALUControl = dec.op;
        flagw_req  = funct[0] ? dec.flagw : 2'b00;
        state_next = ALUWB;
      end
      ALUWB: begin
        regw       = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        branch     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  assign pc_dest = (rd == PC_REG);
  assign pcs     = (pc_dest & regw) | branch;
  assign ImmSrc  = op;
  assign RegSrc  = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

  // Enables are forced low while reset is held so an aborted access never
  // leaves a partial write behind.
  assign PCWrite  = reset & (next_pc | (pcs & condex));
  assign IRWrite  = reset & irw;
  assign RegWrite = reset & regw & condex & ~pc_dest;
  assign MemWrite = reset & memw & condex;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a per-cycle expected control
// vector is queued when inputs are driven and compared on the falling edge.
module tb_multicycle_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         mem_ready;
  logic         PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]   ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;

  multicycle_controller #(.PC_REG(4'hF), .FLAG_RST(4'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  typedef enum int {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AWB, T_B} step_t;
  typedef struct {
    string       tag;
    logic [16:0] vec;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  mflags;
  logic        cur_ok;
  string       cur_name;
  logic [16:0] obs;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Odd codes are the inverse of the preceding even code.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return c[0] ? ~base : base;
  endfunction

  function automatic logic [1:0] alu_model(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [16:0] exp_ctrl(input step_t st, input logic [19:0] ins,
                                           input logic ok, input logic rdy);
    logic pcw, adr, mw, irw, sa, rw, wb_pc;
    logic [1:0] rs, alc, sbs, imm, rsrc;
    {pcw, adr, mw, irw, sa, rw} = '0;
    rs = 2'b00; alc = 2'b00; sbs = 2'b00;
    imm   = ins[15:14];
    rsrc  = {ins[15:14] == 2'b01 && !ins[8], ins[15:14] == 2'b10};
    wb_pc = (ins[3:0] == 4'hF);
    case (st)
      T_F:   begin sa = 1; sbs = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      T_D:   begin sa = 1; sbs = 2'b10; rs = 2'b10; end
      T_MA:  sbs = 2'b01;
      T_MR:  adr = 1;
      T_MWB: begin rs = 2'b01; rw = ok && !wb_pc; pcw = ok && wb_pc; end
      T_MW:  begin adr = 1; mw = ok; end
      T_ER:  alc = alu_model(ins[12:9]);
      T_EI:  begin sbs = 2'b01; alc = alu_model(ins[12:9]); end
      T_AWB: begin rw = ok && !wb_pc; pcw = ok && wb_pc; end
      T_B:   begin sbs = 2'b01; rs = 2'b10; pcw = ok; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, alc, sa, sbs, imm, rsrc, rw};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, 32'(obs), 32'(e.vec));
    end
  end

  task automatic push_exp(input step_t st, input logic rdy);
    mem_ready = rdy;
    sb.push_back('{tag: $sformatf("%s/%s", cur_name, st.name()),
                   vec: exp_ctrl(st, Instr, cur_ok, rdy)});
  endtask

  task automatic step(input step_t st, input logic rdy);
    push_exp(st, rdy);
    @(posedge clk); #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic begin_instr(input string nm, input logic [19:0] ins, input logic [3:0] af);
    cur_name = nm;
    Instr    = ins;
    ALUFlags = af;
    cur_ok   = cond_ok(ins[19:16], mflags);
  endtask

  task automatic run_instr(input string nm, input logic [19:0] ins, input logic [3:0] af,
                           input int mstall, input int fstall);
    logic [5:0] fn;
    begin_instr(nm, ins, af);
    fn = ins[13:8];
    repeat (fstall) step(T_F, 1'b0);
    step(T_F, 1'b1);
    step(T_D, rnd());
    case (ins[15:14])
      2'b00: begin
        step(fn[5] ? T_EI : T_ER, rnd());
        if (cur_ok && fn[0]) begin
          if (fn[4:1] == 4'b0100 || fn[4:1] == 4'b0010) mflags = af;
          else if (fn[4:1] == 4'b0000 || fn[4:1] == 4'b1100) mflags[3:2] = af[3:2];
        end
        step(T_AWB, rnd());
      end
      2'b01: begin
        step(T_MA, rnd());
        if (fn[0]) begin
          repeat (mstall) step(T_MR, 1'b0);
          step(T_MR, 1'b1);
          step(T_MWB, rnd());
        end else begin
          repeat (mstall) step(T_MW, 1'b0);
          step(T_MW, 1'b1);
        end
      end
      2'b10: step(T_B, rnd());
      default: ;
    endcase
  endtask

  initial begin
    reset     = 1'b0;
    Instr     = '0;
    ALUFlags  = '0;
    mem_ready = 1'b1;
    mflags    = 4'h0;
    cur_ok    = 1'b0;
    cur_name  = "idle";
    repeat (2) @(posedge clk);
    #1;
    check("rst_pcwrite",  32'(PCWrite),  32'd0);
    check("rst_irwrite",  32'(IRWrite),  32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    reset = 1'b1;

    // {cond, op, funct, Rn, Rd}
    run_instr("adds_imm",  {4'hE, 2'b00, 6'b101001, 4'h2, 4'h1}, 4'b0100, 0, 0);
    run_instr("addne",     {4'h1, 2'b00, 6'b001000, 4'h2, 4'h3}, 4'b1111, 0, 0);
    run_instr("ldr_stall", {4'hE, 2'b01, 6'b011001, 4'h2, 4'h5}, 4'b0000, 3, 0);
    run_instr("b_al",      {4'hE, 2'b10, 6'b101010, 4'h3, 4'h4}, 4'b0000, 0, 0);
    run_instr("bne_z",     {4'h1, 2'b10, 6'b000001, 4'h3, 4'h4}, 4'b0000, 0, 0);
    run_instr("undef_op",  {4'hE, 2'b11, 6'b111111, 4'h1, 4'h2}, 4'b1111, 0, 0);
    run_instr("beq_z",     {4'h0, 2'b10, 6'b010101, 4'h0, 4'h0}, 4'b0000, 0, 0);
    run_instr("subs_fst",  {4'hE, 2'b00, 6'b000101, 4'h1, 4'h2}, 4'b1001, 0, 2);
    run_instr("addge",     {4'hA, 2'b00, 6'b101000, 4'h1, 4'h6}, 4'b0000, 0, 0);
    run_instr("ands",      {4'hE, 2'b00, 6'b100001, 4'h1, 4'h6}, 4'b0110, 0, 0);
    run_instr("orrcs",     {4'h2, 2'b00, 6'b111000, 4'h1, 4'h7}, 4'b0000, 0, 0);
    run_instr("orrvs",     {4'h6, 2'b00, 6'b011000, 4'h1, 4'h7}, 4'b0000, 0, 0);
    run_instr("eors",      {4'hE, 2'b00, 6'b100011, 4'h1, 4'h8}, 4'b1000, 0, 0);
    run_instr("orrmi",     {4'h4, 2'b00, 6'b011000, 4'h1, 4'h8}, 4'b0000, 0, 0);
    run_instr("add_pc",    {4'hE, 2'b00, 6'b101000, 4'h2, 4'hF}, 4'b0000, 0, 0);
    run_instr("add_nv",    {4'hF, 2'b00, 6'b101000, 4'h2, 4'h1}, 4'b0000, 0, 0);
    run_instr("str_stall", {4'hE, 2'b01, 6'b011000, 4'h2, 4'h3}, 4'b0000, 1, 0);

    // Abort a store mid-strobe with an asynchronous reset.
    begin_instr("str_rst", {4'hE, 2'b01, 6'b011000, 4'h2, 4'h3}, 4'b0000);
    step(T_F, 1'b1);
    step(T_D, 1'b1);
    step(T_MA, 1'b1);
    push_exp(T_MW, 1'b0);
    #5;
    mem_ready = 1'b1;
    reset     = 1'b0;
    #1;
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    check("abort_pcwrite",  32'(PCWrite),  32'd0);
    check("abort_irwrite",  32'(IRWrite),  32'd0);
    @(posedge clk); #1;
    check("abort_hold_irwrite", 32'(IRWrite), 32'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    mflags = 4'h0;

    run_instr("beq_after_rst", {4'h0, 2'b10, 6'b000011, 4'h0, 4'h0}, 4'b0000, 0, 0);
    run_instr("bne_after_rst", {4'h1, 2'b10, 6'b000011, 4'h0, 4'h0}, 4'b0000, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
